hpdcache_mshr_mt: RTL and testbench



---
 rtl/hpdcache_mshr_mt_if.sv | 70 +++++++
 rtl/hpdcache_mshr_mt.sv | 242 ++++++++++++++++++++++++
 tb/tb_hpdcache_mshr_mt.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_mshr_mt_if.sv
// hpdcache_mshr_mt_if: request/ack/replay bundle of the multi-target MSHR.
//   alloc_*  : miss allocation/merge request (valid/ready) plus result
//   ack_*    : refill acknowledge (valid/ready)
//   rsp_*    : replayed targets (valid/ready)
//   dbg_state_o : drain FSM state (0 idle, 1 drain)
// Signal suffixes are from the MSHR's point of view (slave modport).
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; ready never depends on valid, and the
// producer keeps valid and payload stable until the transfer.
interface hpdcache_mshr_mt_if #(
  parameter int NEntries   = 4,
  parameter int NTargets   = 4,
  parameter int NlineWidth = 26,
  parameter int ReqIdWidth = 6,
  parameter int SrcIdWidth = 3,
  parameter int WordWidth  = 3,
  parameter int WayWidth   = 2,
  localparam int IdW       = (NEntries > 1) ? $clog2(NEntries) : 1
) ();
  logic                  alloc_valid_i;
  logic                  alloc_ready_o;
  logic [NlineWidth-1:0] alloc_nline_i;
  logic [ReqIdWidth-1:0] alloc_req_id_i;
  logic [SrcIdWidth-1:0] alloc_src_id_i;
  logic [WordWidth-1:0]  alloc_word_i;
  logic                  alloc_need_rsp_i;
  logic [WayWidth-1:0]   alloc_victim_way_i;
  logic                  alloc_primary_o;
  logic [IdW-1:0]        alloc_id_o;

  logic                  ack_valid_i;
  logic                  ack_ready_o;
  logic [IdW-1:0]        ack_id_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [NlineWidth-1:0] rsp_nline_o;
  logic [WayWidth-1:0]   rsp_victim_way_o;
  logic [ReqIdWidth-1:0] rsp_req_id_o;
  logic [SrcIdWidth-1:0] rsp_src_id_o;
  logic [WordWidth-1:0]  rsp_word_o;
  logic                  rsp_need_rsp_o;
  logic                  rsp_last_o;

  logic                  dbg_state_o;

  modport slave (
    input  alloc_valid_i, alloc_nline_i, alloc_req_id_i, alloc_src_id_i,
           alloc_word_i, alloc_need_rsp_i, alloc_victim_way_i,
    output alloc_ready_o, alloc_primary_o, alloc_id_o,
    input  ack_valid_i, ack_id_i,
    output ack_ready_o,
    input  rsp_ready_i,
    output rsp_valid_o, rsp_nline_o, rsp_victim_way_o, rsp_req_id_o,
           rsp_src_id_o, rsp_word_o, rsp_need_rsp_o, rsp_last_o,
    output dbg_state_o
  );

  modport master (
    output alloc_valid_i, alloc_nline_i, alloc_req_id_i, alloc_src_id_i,
           alloc_word_i, alloc_need_rsp_i, alloc_victim_way_i,
    input  alloc_ready_o, alloc_primary_o, alloc_id_o,
    output ack_valid_i, ack_id_i,
    input  ack_ready_o,
    output rsp_ready_i,
    input  rsp_valid_o, rsp_nline_o, rsp_victim_way_o, rsp_req_id_o,
           rsp_src_id_o, rsp_word_o, rsp_need_rsp_o, rsp_last_o,
    input  dbg_state_o
  );
endinterface

// File: rtl/hpdcache_mshr_mt.sv
// hpdcache_mshr_mt: multi-target miss status holding register.
// Each fully-associative entry tracks one outstanding line and collects up to
// NTargets misses to it. A refill acknowledge starts the drain FSM, which
// replays the entry's targets one per cycle and then frees the entry.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   empty_o       : no valid entry
//   full_o        : every entry valid
//   mif (slave)   : alloc / ack / rsp channels and drain FSM debug state
module hpdcache_mshr_mt #(
  parameter int NEntries   = 4,
  parameter int NTargets   = 4,
  parameter int NlineWidth = 26,
  parameter int ReqIdWidth = 6,
  parameter int SrcIdWidth = 3,
  parameter int WordWidth  = 3,
  parameter int WayWidth   = 2,
  localparam int IdW       = (NEntries > 1) ? $clog2(NEntries) : 1,
  localparam int CntW      = $clog2(NTargets + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  output logic                empty_o,
  output logic                full_o,
  hpdcache_mshr_mt_if.slave   mif
);

  typedef struct packed {
    logic [ReqIdWidth-1:0] req_id;
    logic [SrcIdWidth-1:0] src_id;
    logic [WordWidth-1:0]  word;
    logic                  need_rsp;
  } tgt_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_DRAIN = 1'b1} state_e;

  logic [NEntries-1:0]   valid_q, valid_d;
  logic [NEntries-1:0]   draining_q, draining_d;
  logic [NlineWidth-1:0] nline_q [NEntries];
  logic [NlineWidth-1:0] nline_d [NEntries];
  logic [WayWidth-1:0]   way_q [NEntries];
  logic [WayWidth-1:0]   way_d [NEntries];
  logic [CntW-1:0]       cnt_q [NEntries];
  logic [CntW-1:0]       cnt_d [NEntries];
  tgt_t                  tgt_q [NEntries][NTargets];
  tgt_t                  tgt_d [NEntries][NTargets];

  state_e                state_q, state_d;
  logic [IdW-1:0]        ent_q, ent_d;
  logic [CntW-1:0]       rd_ptr_q, rd_ptr_d;

  // Lookup / free search
  logic                  hit, free_any, hit_drn;
  logic [IdW-1:0]        hit_idx, free_idx, alloc_id;
  logic [CntW-1:0]       hit_cnt;
  logic                  alloc_ready, alloc_fire;
  tgt_t                  tgt_new;

  // Drain view of the selected entry
  logic                  drain, is_last, ack_entry_valid;
  logic [CntW-1:0]       ent_cnt;
  logic [NlineWidth-1:0] ent_nline;
  logic [WayWidth-1:0]   ent_way;
  tgt_t                  cur_tgt;

  // Descending scan so the lowest index wins for both the hit and the free
  // slot. At most one entry can match a line, since a matching line never
  // opens a second entry.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NEntries - 1; i >= 0; i--) begin
      if (valid_q[i] && (nline_q[i] == mif.alloc_nline_i)) begin
        hit     = 1'b1;
        hit_idx = IdW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IdW'(i);
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    hit_drn = 1'b0;
    for (int i = 0; i < NEntries; i++) begin
      if (IdW'(i) == hit_idx) begin
        hit_cnt = cnt_q[i];
        hit_drn = draining_q[i];
      end
    end
  end

  // A line under drain refuses merges, so alloc and drain never share an entry.
  assign alloc_ready = hit ? ((hit_cnt < CntW'(NTargets)) && !hit_drn) : free_any;
  assign alloc_id    = hit ? hit_idx : free_idx;
  assign alloc_fire  = mif.alloc_valid_i && alloc_ready;

  assign tgt_new = '{req_id:   mif.alloc_req_id_i,
                     src_id:   mif.alloc_src_id_i,
                     word:     mif.alloc_word_i,
                     need_rsp: mif.alloc_need_rsp_i};

  always_comb begin
    ent_cnt         = '0;
    ent_nline       = '0;
    ent_way         = '0;
    cur_tgt         = '0;
    ack_entry_valid = 1'b0;
    for (int i = 0; i < NEntries; i++) begin
      if (IdW'(i) == ent_q) begin
        ent_cnt   = cnt_q[i];
        ent_nline = nline_q[i];
        ent_way   = way_q[i];
        for (int j = 0; j < NTargets; j++) begin
          if (CntW'(j) == rd_ptr_q) cur_tgt = tgt_q[i][j];
        end
      end
      if ((IdW'(i) == mif.ack_id_i) && valid_q[i]) ack_entry_valid = 1'b1;
    end
  end

  assign drain   = (state_q == ST_DRAIN);
  assign is_last = drain && (rd_ptr_q == (ent_cnt - CntW'(1)));

  // Next state: allocation/merge and drain updates touch disjoint entries.
  always_comb begin
    valid_d    = valid_q;
    draining_d = draining_q;
    nline_d    = nline_q;
    way_d      = way_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    state_d    = state_q;
    ent_d      = ent_q;
    rd_ptr_d   = rd_ptr_q;

    if (alloc_fire) begin
      for (int i = 0; i < NEntries; i++) begin
        if (IdW'(i) == alloc_id) begin
          if (hit) begin
            for (int j = 0; j < NTargets; j++) begin
              if (CntW'(j) == cnt_q[i]) tgt_d[i][j] = tgt_new;
            end
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end else begin
            valid_d[i]    = 1'b1;
            draining_d[i] = 1'b0;
            nline_d[i]    = mif.alloc_nline_i;
            way_d[i]      = mif.alloc_victim_way_i;
            cnt_d[i]      = CntW'(1);
            tgt_d[i][0]   = tgt_new;
          end
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (mif.ack_valid_i) begin
          state_d  = ST_DRAIN;
          ent_d    = mif.ack_id_i;
          rd_ptr_d = '0;
          for (int i = 0; i < NEntries; i++) begin
            if (IdW'(i) == mif.ack_id_i) draining_d[i] = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (mif.rsp_ready_i) begin
          if (is_last) begin
            state_d  = ST_IDLE;
            rd_ptr_d = '0;
            for (int i = 0; i < NEntries; i++) begin
              if (IdW'(i) == ent_q) begin
                valid_d[i]    = 1'b0;
                draining_d[i] = 1'b0;
                cnt_d[i]      = '0;
              end
            end
          end else begin
            rd_ptr_d = rd_ptr_q + CntW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= '0;
      draining_q <= '0;
      state_q    <= ST_IDLE;
      ent_q      <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < NEntries; i++) begin
        nline_q[i] <= '0;
        way_q[i]   <= '0;
        cnt_q[i]   <= '0;
        for (int j = 0; j < NTargets; j++) tgt_q[i][j] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      draining_q <= draining_d;
      nline_q    <= nline_d;
      way_q      <= way_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      state_q    <= state_d;
      ent_q      <= ent_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  assign empty_o = ~|valid_q;
  assign full_o  = &valid_q;

  assign mif.alloc_ready_o   = alloc_ready;
  assign mif.alloc_primary_o = ~hit;
  assign mif.alloc_id_o      = alloc_id;
  assign mif.ack_ready_o     = ~drain;
  assign mif.dbg_state_o     = state_q;

  // Payload is forced to zero while idle so the bus is quiet between drains.
  assign mif.rsp_valid_o      = drain;
  assign mif.rsp_last_o       = is_last;
  assign mif.rsp_nline_o      = drain ? ent_nline : '0;
  assign mif.rsp_victim_way_o = drain ? ent_way : '0;
  assign mif.rsp_req_id_o     = drain ? cur_tgt.req_id : '0;
  assign mif.rsp_src_id_o     = drain ? cur_tgt.src_id : '0;
  assign mif.rsp_word_o       = drain ? cur_tgt.word : '0;
  assign mif.rsp_need_rsp_o   = drain ? cur_tgt.need_rsp : '0;

  // A refill can only be acknowledged for an entry that is outstanding.
  a_ack_valid_entry: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mif.ack_valid_i && (state_q == ST_IDLE)) |-> ack_entry_valid);

endmodule

// File: tb/tb_hpdcache_mshr_mt.sv
module tb_hpdcache_mshr_mt;
  localparam int NEntries = 4;
  localparam int NTargets = 4;
  localparam int IdW      = 2;
  localparam int RspW     = 26 + 2 + 6 + 3 + 3 + 1 + 1;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni;
  logic empty_o, full_o;
  always #5 clk_i = ~clk_i;

  hpdcache_mshr_mt_if #(.NEntries(NEntries), .NTargets(NTargets)) mif ();

  hpdcache_mshr_mt #(.NEntries(NEntries), .NTargets(NTargets)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .empty_o (empty_o),
    .full_o  (full_o),
    .mif     (mif)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [IdW:0]    exp_alloc_q[$];
  logic [RspW-1:0] exp_rsp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT completes a transfer.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (mif.alloc_valid_i && mif.alloc_ready_o) begin
        if (exp_alloc_q.size() == 0) check("unexpected_alloc_accept", 64'd1, 64'd0);
        else check("alloc_result", 64'({mif.alloc_primary_o, mif.alloc_id_o}),
                   64'(exp_alloc_q.pop_front()));
      end
      if (mif.rsp_valid_o && mif.rsp_ready_i) begin
        if (exp_rsp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
        else check("rsp_target",
                   64'({mif.rsp_nline_o, mif.rsp_victim_way_o, mif.rsp_req_id_o,
                        mif.rsp_src_id_o, mif.rsp_word_o, mif.rsp_need_rsp_o,
                        mif.rsp_last_o}),
                   64'(exp_rsp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic set_alloc(input logic [25:0] nline, input logic [5:0] req, input logic [2:0] src,
                           input logic [2:0] word, input logic need, input logic [1:0] way);
    mif.alloc_nline_i      = nline;
    mif.alloc_req_id_i     = req;
    mif.alloc_src_id_i     = src;
    mif.alloc_word_i       = word;
    mif.alloc_need_rsp_i   = need;
    mif.alloc_victim_way_i = way;
  endtask

  task automatic alloc_ok(input logic [25:0] nline, input logic [5:0] req, input logic [2:0] src,
                          input logic [2:0] word, input logic need, input logic [1:0] way,
                          input logic primary, input logic [IdW-1:0] id);
    set_alloc(nline, req, src, word, need, way);
    mif.alloc_valid_i = 1'b1;
    exp_alloc_q.push_back({primary, id});
    @(negedge clk_i);
    check("alloc_ready", 64'(mif.alloc_ready_o), 64'd1);
    @(posedge clk_i); #1;
    mif.alloc_valid_i = 1'b0;
  endtask

  task automatic alloc_stall(input logic [25:0] nline);
    set_alloc(nline, 6'd63, 3'd0, 3'd0, 1'b0, 2'd0);
    mif.alloc_valid_i = 1'b1;
    @(negedge clk_i);
    check("alloc_stall_ready", 64'(mif.alloc_ready_o), 64'd0);
    @(posedge clk_i); #1;
    mif.alloc_valid_i = 1'b0;
  endtask

  task automatic push_rsp(input logic [25:0] nline, input logic [1:0] way, input logic [5:0] req,
                          input logic [2:0] src, input logic [2:0] word, input logic need,
                          input logic last);
    exp_rsp_q.push_back({nline, way, req, src, word, need, last});
  endtask

  // Ack, then check the first target appears one cycle later.
  task automatic send_ack(input logic [IdW-1:0] id);
    mif.ack_valid_i = 1'b1;
    mif.ack_id_i    = id;
    @(negedge clk_i);
    check("ack_ready_idle", 64'(mif.ack_ready_o), 64'd1);
    @(posedge clk_i); #1;
    mif.ack_valid_i = 1'b0;
    @(negedge clk_i);
    check("ack_to_rsp_latency", 64'(mif.rsp_valid_o), 64'd1);
    @(posedge clk_i); #1;
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_i);
      if (mif.ack_ready_o) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done_in_budget", 64'(done), 64'd1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_ni = 1'b0;
    mif.alloc_valid_i = 1'b0;
    set_alloc(26'd0, 6'd0, 3'd0, 3'd0, 1'b0, 2'd0);
    mif.ack_valid_i = 1'b0;
    mif.ack_id_i    = '0;
    mif.rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset state
    @(negedge clk_i);
    check("rst_empty", 64'(empty_o), 64'd1);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_ack_ready", 64'(mif.ack_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(mif.rsp_valid_o), 64'd0);
    check("rst_rsp_last", 64'(mif.rsp_last_o), 64'd0);
    check("rst_alloc_ready", 64'(mif.alloc_ready_o), 64'd1);
    check("rst_alloc_primary", 64'(mif.alloc_primary_o), 64'd1);
    check("rst_alloc_id", 64'(mif.alloc_id_o), 64'd0);
    check("rst_rsp_req_id", 64'(mif.rsp_req_id_o), 64'd0);
    check("rst_rsp_nline", 64'(mif.rsp_nline_o), 64'd0);
    check("rst_dbg_state", 64'(mif.dbg_state_o), 64'd0);
    @(posedge clk_i); #1;

    // Single miss
    alloc_ok(26'h100, 6'd5, 3'd1, 3'd2, 1'b1, 2'd3, 1'b1, 2'd0);
    @(negedge clk_i);
    check("single_not_empty", 64'(empty_o), 64'd0);
    @(posedge clk_i); #1;
    push_rsp(26'h100, 2'd3, 6'd5, 3'd1, 3'd2, 1'b1, 1'b1);
    send_ack(2'd0);
    @(negedge clk_i);
    check("single_empty_after", 64'(empty_o), 64'd1);
    check("single_ack_ready_after", 64'(mif.ack_ready_o), 64'd1);
    @(posedge clk_i); #1;

    // Merge four targets, fifth stalls
    for (int i = 1; i <= 4; i++) begin
      alloc_ok(26'h200, 6'(i), 3'd4, 3'(i), i[0], 2'd1, (i == 1), 2'd0);
      push_rsp(26'h200, 2'd1, 6'(i), 3'd4, 3'(i), i[0], (i == 4));
    end
    alloc_stall(26'h200);
    send_ack(2'd0);
    // Ack presented mid-drain must be ignored.
    for (int k = 0; k < 3; k++) begin
      mif.ack_valid_i = (k < 2);
      mif.ack_id_i    = 2'd0;
      @(negedge clk_i);
      check("ack_ready_busy", 64'(mif.ack_ready_o), 64'd0);
      @(posedge clk_i); #1;
    end
    mif.ack_valid_i = 1'b0;
    @(negedge clk_i);
    check("merge_ack_ready_after", 64'(mif.ack_ready_o), 64'd1);
    check("merge_empty_after", 64'(empty_o), 64'd1);
    @(posedge clk_i); #1;

    // Full
    for (int i = 0; i < 4; i++)
      alloc_ok(26'((i + 1) * 16), 6'(8 + i), 3'd0, 3'd0, 1'b0, 2'(i), 1'b1, 2'(i));
    @(negedge clk_i);
    check("full_set", 64'(full_o), 64'd1);
    @(posedge clk_i); #1;
    alloc_stall(26'h50);
    // Drain entry 2 while 0x50 waits; it may only go in after the free edge.
    push_rsp(26'h30, 2'd2, 6'd10, 3'd0, 3'd0, 1'b0, 1'b1);
    set_alloc(26'h50, 6'd30, 3'd7, 3'd7, 1'b1, 2'd2);
    mif.alloc_valid_i = 1'b1;
    mif.ack_valid_i   = 1'b1;
    mif.ack_id_i      = 2'd2;
    @(negedge clk_i);
    check("full_ack_ready", 64'(mif.ack_ready_o), 64'd1);
    check("full_wait_ready0", 64'(mif.alloc_ready_o), 64'd0);
    @(posedge clk_i); #1;
    mif.ack_valid_i = 1'b0;
    @(negedge clk_i);
    check("full_rsp_valid", 64'(mif.rsp_valid_o), 64'd1);
    check("full_same_cycle_ready0", 64'(mif.alloc_ready_o), 64'd0);
    @(posedge clk_i); #1;
    exp_alloc_q.push_back({1'b1, 2'd2});
    @(negedge clk_i);
    check("full_reuse_ready", 64'(mif.alloc_ready_o), 64'd1);
    @(posedge clk_i); #1;
    mif.alloc_valid_i = 1'b0;
    // Drain the rest: entries 0, 1, 3, then 2 (now 0x50)
    push_rsp(26'h10, 2'd0, 6'd8, 3'd0, 3'd0, 1'b0, 1'b1);
    send_ack(2'd0); wait_idle(8);
    push_rsp(26'h20, 2'd1, 6'd9, 3'd0, 3'd0, 1'b0, 1'b1);
    send_ack(2'd1); wait_idle(8);
    push_rsp(26'h40, 2'd3, 6'd11, 3'd0, 3'd0, 1'b0, 1'b1);
    send_ack(2'd3); wait_idle(8);
    push_rsp(26'h50, 2'd2, 6'd30, 3'd7, 3'd7, 1'b1, 1'b1);
    send_ack(2'd2); wait_idle(8);

    // Draining entry blocks merges; other lines still allocate; outputs hold
    for (int i = 10; i <= 12; i++) begin
      alloc_ok(26'h300, 6'(i), 3'd5, 3'd3, 1'b1, 2'd0, (i == 10), 2'd0);
      push_rsp(26'h300, 2'd0, 6'(i), 3'd5, 3'd3, 1'b1, (i == 12));
    end
    mif.rsp_ready_i = 1'b0;
    send_ack(2'd0);
    alloc_stall(26'h300);
    @(negedge clk_i);
    check("bp_req_id", 64'(mif.rsp_req_id_o), 64'd10);
    check("bp_nline", 64'(mif.rsp_nline_o), 64'h300);
    @(posedge clk_i); #1;
    alloc_ok(26'h400, 6'd20, 3'd6, 3'd4, 1'b0, 2'd1, 1'b1, 2'd1);
    @(negedge clk_i);
    check("bp_valid_held", 64'(mif.rsp_valid_o), 64'd1);
    check("bp_req_id_held", 64'(mif.rsp_req_id_o), 64'd10);
    check("bp_last_held", 64'(mif.rsp_last_o), 64'd0);
    check("bp_dbg_state", 64'(mif.dbg_state_o), 64'd1);
    @(posedge clk_i); #1;
    mif.rsp_ready_i = 1'b1;
    wait_idle(10);

    // Async reset mid-drain: entry 1 holds 4 targets, only 2 get out
    for (int i = 21; i <= 23; i++)
      alloc_ok(26'h400, 6'(i), 3'd6, 3'd4, 1'b0, 2'd0, 1'b0, 2'd1);
    push_rsp(26'h400, 2'd1, 6'd20, 3'd6, 3'd4, 1'b0, 1'b0);
    push_rsp(26'h400, 2'd1, 6'd21, 3'd6, 3'd4, 1'b0, 1'b0);
    send_ack(2'd1);
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_rsp_valid", 64'(mif.rsp_valid_o), 64'd0);
    check("rst_mid_empty", 64'(empty_o), 64'd1);
    check("rst_mid_ack_ready", 64'(mif.ack_ready_o), 64'd1);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    alloc_ok(26'h400, 6'd40, 3'd2, 3'd5, 1'b1, 2'd2, 1'b1, 2'd0);
    push_rsp(26'h400, 2'd2, 6'd40, 3'd2, 3'd5, 1'b1, 1'b1);
    send_ack(2'd0);
    wait_idle(8);

    check("alloc_queue_drained", 64'(exp_alloc_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(exp_rsp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
